// File: rtl/datamem_arbiter.sv
// Two-port arbiter in front of a single-port 256x8 data memory: round-robin on
// contention, optional locked bursts capped at MAXBURST, registered read return.
module datamem_arbiter #(
    parameter int W        = 8,
    parameter int A        = 8,
    parameter int MAXBURST = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         ReqA,
    input  logic         ReqB,
    input  logic         WeA,
    input  logic         WeB,
    input  logic [A-1:0] AddrA,
    input  logic [A-1:0] AddrB,
    input  logic [W-1:0] WDataA,
    input  logic [W-1:0] WDataB,
    input  logic         LockA,
    input  logic         LockB,
    output logic         GntA,
    output logic         GntB,
    output logic [W-1:0] RDataA,
    output logic [W-1:0] RDataB,
    output logic         RValidA,
    output logic         RValidB,
    output logic         MemWriteEn,
    output logic [A-1:0] MemAddress,
    output logic [W-1:0] MemDataIn,
    input  logic [W-1:0] MemDataOut
);

    localparam int BW = $clog2(MAXBURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAXBURST);
    localparam logic [BW-1:0] BURST_ONE = BW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    state_t        state_reg;
    logic          last_gnt_reg;     // 0 = A was granted last, 1 = B
    logic [BW-1:0] burst_cnt_reg;
    logic [A-1:0]  addr_hold_reg;
    logic [W-1:0]  data_hold_reg;
    logic [W-1:0]  rdata_a_reg;
    logic [W-1:0]  rdata_b_reg;
    logic          rvalid_a_reg;
    logic          rvalid_b_reg;

    logic          idle_a;
    logic          idle_b;
    logic          sel_a;
    logic          sel_b;
    logic          gnt_a;
    logic          gnt_b;
    logic          burst_full;
    logic [BW-1:0] burst_inc;
    logic [BW-1:0] next_cnt_a;
    logic [BW-1:0] next_cnt_b;

    // Fair choice used whenever no port currently owns the memory.
    always_comb begin
        idle_a = 1'b0;
        idle_b = 1'b0;
        if (ReqA && !ReqB) begin
            idle_a = 1'b1;
        end else if (ReqB && !ReqA) begin
            idle_b = 1'b1;
        end else if (ReqA && ReqB) begin
            idle_a = last_gnt_reg;
            idle_b = !last_gnt_reg;
        end
    end

    assign burst_full = (burst_cnt_reg == BURST_MAX);

    always_comb begin
        sel_a = idle_a;
        sel_b = idle_b;
        case (state_reg)
            OWN_A: begin
                if (ReqA) begin
                    sel_a = !(ReqB && burst_full);
                    sel_b = ReqB && burst_full;
                end
            end
            OWN_B: begin
                if (ReqB) begin
                    sel_b = !(ReqA && burst_full);
                    sel_a = ReqA && burst_full;
                end
            end
            default: begin
                sel_a = idle_a;
                sel_b = idle_b;
            end
        endcase
    end

    // Reset gates the grants combinationally so nothing reaches memory while it is low.
    assign gnt_a = sel_a && Reset;
    assign gnt_b = sel_b && Reset;

    assign GntA       = gnt_a;
    assign GntB       = gnt_b;
    assign MemWriteEn = (gnt_a && WeA) || (gnt_b && WeB);

    always_comb begin
        MemAddress = addr_hold_reg;
        MemDataIn  = data_hold_reg;
        if (!Reset) begin
            MemAddress = '0;
            MemDataIn  = '0;
        end else if (gnt_a) begin
            MemAddress = AddrA;
            MemDataIn  = WDataA;
        end else if (gnt_b) begin
            MemAddress = AddrB;
            MemDataIn  = WDataB;
        end
    end

    // A burst continues counting only when the same port already owned the memory.
    assign burst_inc  = burst_full ? BURST_MAX : burst_cnt_reg + BURST_ONE;
    assign next_cnt_a = (state_reg == OWN_A) ? burst_inc : BURST_ONE;
    assign next_cnt_b = (state_reg == OWN_B) ? burst_inc : BURST_ONE;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_reg     <= IDLE;
            last_gnt_reg  <= 1'b1;
            burst_cnt_reg <= '0;
            addr_hold_reg <= '0;
            data_hold_reg <= '0;
            rdata_a_reg   <= '0;
            rdata_b_reg   <= '0;
            rvalid_a_reg  <= 1'b0;
            rvalid_b_reg  <= 1'b0;
        end else begin
            rvalid_a_reg <= gnt_a && !WeA;
            rvalid_b_reg <= gnt_b && !WeB;
            if (gnt_a && !WeA) begin
                rdata_a_reg <= MemDataOut;
            end
            if (gnt_b && !WeB) begin
                rdata_b_reg <= MemDataOut;
            end

            if (gnt_a) begin
                last_gnt_reg  <= 1'b0;
                addr_hold_reg <= AddrA;
                data_hold_reg <= WDataA;
                if (LockA) begin
                    state_reg     <= OWN_A;
                    burst_cnt_reg <= next_cnt_a;
                end else begin
                    state_reg     <= IDLE;
                    burst_cnt_reg <= '0;
                end
            end else if (gnt_b) begin
                last_gnt_reg  <= 1'b1;
                addr_hold_reg <= AddrB;
                data_hold_reg <= WDataB;
                if (LockB) begin
                    state_reg     <= OWN_B;
                    burst_cnt_reg <= next_cnt_b;
                end else begin
                    state_reg     <= IDLE;
                    burst_cnt_reg <= '0;
                end
            end else begin
                state_reg     <= IDLE;
                burst_cnt_reg <= '0;
            end
        end
    end

    assign RDataA  = rdata_a_reg;
    assign RDataB  = rdata_b_reg;
    assign RValidA = rvalid_a_reg;
    assign RValidB = rvalid_b_reg;

endmodule

// File: tb/tb_datamem_arbiter.sv
// Directed bench for datamem_arbiter with a 256x8 memory model behind it
// (combinational read, posedge write). Inputs change on negedge, checks at negedge+1.
module tb_datamem_arbiter;

    logic       Clk;
    logic       Reset;
    logic       ReqA, ReqB, WeA, WeB, LockA, LockB;
    logic [7:0] AddrA, AddrB, WDataA, WDataB;
    logic       GntA, GntB, RValidA, RValidB, MemWriteEn;
    logic [7:0] RDataA, RDataB, MemAddress, MemDataIn, MemDataOut;

    logic [7:0] mem [0:255];
    logic       mem_fill;
    int         tests;
    int         fails;

    datamem_arbiter #(.W(8), .A(8), .MAXBURST(4)) dut (
        .Clk(Clk), .Reset(Reset),
        .ReqA(ReqA), .ReqB(ReqB), .WeA(WeA), .WeB(WeB),
        .AddrA(AddrA), .AddrB(AddrB), .WDataA(WDataA), .WDataB(WDataB),
        .LockA(LockA), .LockB(LockB), .GntA(GntA), .GntB(GntB),
        .RDataA(RDataA), .RDataB(RDataB), .RValidA(RValidA), .RValidB(RValidB),
        .MemWriteEn(MemWriteEn), .MemAddress(MemAddress),
        .MemDataIn(MemDataIn), .MemDataOut(MemDataOut)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Memory contents start as addr ^ 0xA5.
    assign MemDataOut = mem[MemAddress];
    always @(posedge Clk) begin
        if (mem_fill) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hA5;
        end else if (MemWriteEn) begin
            mem[MemAddress] <= MemDataIn;
        end
    end

    task automatic next_cyc;
        @(negedge Clk);
    endtask

    task automatic idle_inputs;
        ReqA = 0; ReqB = 0; WeA = 0; WeB = 0; LockA = 0; LockB = 0;
    endtask

    task automatic test_reset;
        next_cyc();
        mem_fill = 0;
        ReqA = 1; WeA = 1; AddrA = 8'h10; WDataA = 8'h11;
        #1;
        tests++; if (GntA !== 1'b0) begin fails++; $display("FAIL rst_gnt_a: got %b expected 0", GntA); end
        tests++; if (MemWriteEn !== 1'b0) begin fails++; $display("FAIL rst_we: got %b expected 0", MemWriteEn); end
        tests++; if (MemAddress !== 8'h00) begin fails++; $display("FAIL rst_addr: got %h expected 00", MemAddress); end
        tests++; if (RValidA !== 1'b0) begin fails++; $display("FAIL rst_rvalid_a: got %b expected 0", RValidA); end
        next_cyc();
        #1;
        tests++; if (mem[8'h10] !== 8'hB5) begin fails++; $display("FAIL rst_no_write: got %h expected b5", mem[8'h10]); end
        Reset = 1;
        #1;
        tests++; if (GntA !== 1'b1) begin fails++; $display("FAIL rel_gnt_a: got %b expected 1", GntA); end
        tests++; if (MemWriteEn !== 1'b1) begin fails++; $display("FAIL rel_we: got %b expected 1", MemWriteEn); end
        tests++; if (MemAddress !== 8'h10) begin fails++; $display("FAIL rel_addr: got %h expected 10", MemAddress); end
        $display("[TB] reset: A write held off while reset low, granted on release");
    endtask

    task automatic test_write_read;
        next_cyc();
        WDataA = 8'h5A;
        #1;
        tests++; if (GntA !== 1'b1 || MemWriteEn !== 1'b1) begin fails++; $display("FAIL wr_gnt: got gnt=%b we=%b expected 1 1", GntA, MemWriteEn); end
        tests++; if (MemDataIn !== 8'h5A) begin fails++; $display("FAIL wr_data: got %h expected 5a", MemDataIn); end
        next_cyc();
        WeA = 0;
        #1;
        tests++; if (GntA !== 1'b1 || MemWriteEn !== 1'b0) begin fails++; $display("FAIL rd_gnt: got gnt=%b we=%b expected 1 0", GntA, MemWriteEn); end
        tests++; if (RValidA !== 1'b0) begin fails++; $display("FAIL wr_no_rvalid: got %b expected 0", RValidA); end
        next_cyc();
        ReqA = 0;
        #1;
        tests++; if (RValidA !== 1'b1 || RDataA !== 8'h5A) begin fails++; $display("FAIL rd_data: got v=%b d=%h expected 1 5a", RValidA, RDataA); end
        tests++; if (GntA !== 1'b0 || MemWriteEn !== 1'b0 || MemAddress !== 8'h10) begin fails++; $display("FAIL idle_hold: got gnt=%b we=%b addr=%h expected 0 0 10", GntA, MemWriteEn, MemAddress); end
        next_cyc();
        #1;
        tests++; if (RValidA !== 1'b0 || RDataA !== 8'h5A) begin fails++; $display("FAIL rd_pulse: got v=%b d=%h expected 0 5a", RValidA, RDataA); end
        $display("[TB] write_read: A wrote 5a @10 and read it back");
    endtask

    task automatic test_round_robin;
        next_cyc();
        ReqA = 1; ReqB = 1; WeA = 0; WeB = 0; AddrA = 8'h20; AddrB = 8'h30;
        for (int k = 0; k < 4; k++) begin
            #1;
            tests++; if (GntB !== (k % 2 == 0) || GntA !== (k % 2 == 1)) begin fails++; $display("FAIL rr_gnt[%0d]: got a=%b b=%b expected a=%b b=%b", k, GntA, GntB, k % 2 == 1, k % 2 == 0); end
            if (k > 0) begin
                tests++; if (RValidA !== ((k - 1) % 2 == 1) || RValidB !== ((k - 1) % 2 == 0)) begin fails++; $display("FAIL rr_rvalid[%0d]: got a=%b b=%b", k, RValidA, RValidB); end
            end
            next_cyc();
        end
        idle_inputs();
        #1;
        tests++; if (RValidA !== 1'b1 || RValidB !== 1'b0 || RDataA !== 8'h85 || RDataB !== 8'h95) begin fails++; $display("FAIL rr_data: got va=%b vb=%b da=%h db=%h expected 1 0 85 95", RValidA, RValidB, RDataA, RDataB); end
        $display("[TB] round_robin: contended reads alternated B,A,B,A");
    endtask

    task automatic test_lock_burst;
        logic [5:0] exp_b;
        exp_b = 6'b101111;  // bit k = expected GntB in cycle k
        next_cyc();
        ReqA = 1; ReqB = 1; LockB = 1; AddrA = 8'h21; AddrB = 8'h31;
        for (int k = 0; k < 6; k++) begin
            #1;
            tests++; if (GntB !== exp_b[k] || GntA !== !exp_b[k]) begin fails++; $display("FAIL lock_b[%0d]: got a=%b b=%b expected b=%b", k, GntA, GntB, exp_b[k]); end
            tests++; if (MemAddress !== (exp_b[k] ? 8'h31 : 8'h21)) begin fails++; $display("FAIL lock_addr[%0d]: got %h", k, MemAddress); end
            next_cyc();
        end
        idle_inputs();
        #1;
        tests++; if (RValidB !== 1'b1 || RDataB !== 8'h94) begin fails++; $display("FAIL lock_rdata: got v=%b d=%h expected 1 94", RValidB, RDataB); end
        $display("[TB] lock_burst: B held 4 grants, handed to A, then resumed");
    endtask

    task automatic test_lock_release;
        next_cyc();
        ReqA = 1; LockA = 1; AddrA = 8'h22;
        #1;
        tests++; if (GntA !== 1'b1) begin fails++; $display("FAIL lr_gnt_a: got %b expected 1", GntA); end
        next_cyc();
        ReqA = 0; LockA = 0; ReqB = 1; AddrB = 8'h32;
        #1;
        tests++; if (GntB !== 1'b1 || GntA !== 1'b0) begin fails++; $display("FAIL lr_gnt_b: got a=%b b=%b expected 0 1", GntA, GntB); end
        tests++; if (RValidA !== 1'b1 || RDataA !== 8'h87) begin fails++; $display("FAIL lr_rdata_a: got v=%b d=%h expected 1 87", RValidA, RDataA); end
        next_cyc();
        ReqA = 1;
        #1;
        tests++; if (GntA !== 1'b1 || GntB !== 1'b0) begin fails++; $display("FAIL lr_rr: got a=%b b=%b expected 1 0", GntA, GntB); end
        next_cyc();
        idle_inputs();
        $display("[TB] lock_release: dropped lock did not hold ownership");
    endtask

    task automatic test_lock_a_handoff;
        next_cyc();
        ReqA = 1; LockA = 1; AddrA = 8'h23; AddrB = 8'h33;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) ReqB = 1;
            #1;
            tests++; if (GntA !== (k < 4) || GntB !== (k == 4)) begin fails++; $display("FAIL hand_a[%0d]: got a=%b b=%b expected a=%b", k, GntA, GntB, k < 4); end
            next_cyc();
        end
        idle_inputs();
        #1;
        tests++; if (RValidB !== 1'b1 || RDataB !== 8'h96) begin fails++; $display("FAIL hand_rdata: got v=%b d=%h expected 1 96", RValidB, RDataB); end
        $display("[TB] lock_a_handoff: A burst capped at 4 once B requested");
    endtask

    task automatic test_back_to_back;
        next_cyc();
        ReqB = 1; WeB = 1; AddrB = 8'h40; WDataB = 8'h77;
        #1;
        tests++; if (GntB !== 1'b1 || MemWriteEn !== 1'b1 || MemDataIn !== 8'h77) begin fails++; $display("FAIL b2b_wr: got g=%b we=%b d=%h expected 1 1 77", GntB, MemWriteEn, MemDataIn); end
        next_cyc();
        ReqB = 0; WeB = 0; ReqA = 1; WeA = 0; AddrA = 8'h40;
        #1;
        tests++; if (GntA !== 1'b1 || RValidB !== 1'b0) begin fails++; $display("FAIL b2b_rd_a: got g=%b vb=%b expected 1 0", GntA, RValidB); end
        next_cyc();
        ReqA = 0; ReqB = 1;
        #1;
        tests++; if (RValidA !== 1'b1 || RDataA !== 8'h77 || GntB !== 1'b1) begin fails++; $display("FAIL b2b_a_ret: got v=%b d=%h gb=%b expected 1 77 1", RValidA, RDataA, GntB); end
        next_cyc();
        idle_inputs();
        #1;
        tests++; if (RValidB !== 1'b1 || RDataB !== 8'h77 || RValidA !== 1'b0) begin fails++; $display("FAIL b2b_b_ret: got vb=%b d=%h va=%b expected 1 77 0", RValidB, RDataB, RValidA); end
        $display("[TB] back_to_back: B write then A read then B read of @40");
    endtask

    task automatic test_reset_mid;
        next_cyc();
        ReqA = 1; WeA = 0; AddrA = 8'h50;
        #1;
        tests++; if (GntA !== 1'b1) begin fails++; $display("FAIL mid_gnt: got %b expected 1", GntA); end
        #2;
        Reset = 0; WeA = 1; WDataA = 8'hEE;
        #1;
        tests++; if (GntA !== 1'b0 || MemWriteEn !== 1'b0 || MemAddress !== 8'h00) begin fails++; $display("FAIL mid_force: got g=%b we=%b a=%h expected 0 0 00", GntA, MemWriteEn, MemAddress); end
        next_cyc();
        #1;
        tests++; if (RValidA !== 1'b0) begin fails++; $display("FAIL mid_rvalid: got %b expected 0", RValidA); end
        tests++; if (mem[8'h50] !== 8'hF5) begin fails++; $display("FAIL mid_mem: got %h expected f5", mem[8'h50]); end
        next_cyc();
        Reset = 1; ReqA = 1; ReqB = 1; WeA = 0; WeB = 0;
        #1;
        tests++; if (GntA !== 1'b1 || GntB !== 1'b0) begin fails++; $display("FAIL mid_tie: got a=%b b=%b expected 1 0", GntA, GntB); end
        next_cyc();
        idle_inputs();
        #1;
        tests++; if (RValidA !== 1'b1 || RDataA !== 8'hF5) begin fails++; $display("FAIL mid_reread: got v=%b d=%h expected 1 f5", RValidA, RDataA); end
        $display("[TB] reset_mid: reset cancelled read return and write, A won first tie");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0; fails = 0;
        Reset = 0; mem_fill = 1;
        idle_inputs();
        AddrA = 0; AddrB = 0; WDataA = 0; WDataB = 0;
        test_reset();
        test_write_read();
        test_round_robin();
        test_lock_burst();
        test_lock_release();
        test_lock_a_handoff();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
